// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: deframes, folds E0/F0 prefixes, queues scan codes show-ahead.
// Latency: entry visible 2 cycles after the stop-bit fall pulse; backpressure: full FIFO drops the code and sets overflow.

// Generic show-ahead FIFO, head valid combinationally from registered storage.
// Latency 1 cycle write-to-read; wr_rdy stays high when full if the head is popped in the same cycle.
module ps2_rx_fifo_q #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         wr_rdy,
  input  logic         rd_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  logic         empty, wr_fire, rd_fire;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rd_vld  = !empty;
  assign rd_fire = rd_rdy && !empty;
  assign wr_rdy  = !full || rd_fire;
  assign wr_fire = wr_vld && wr_rdy;
  assign rd_dat  = mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_fire) begin
        mem[wp[AW-1:0]] <= wr_dat;
        wp <= wp + {{AW{1'b0}}, 1'b1};
      end
      if (rd_fire) rp <= rp + {{AW{1'b0}}, 1'b1};
    end
  end
endmodule

// PS/2 receiver top: 2-FF sync, glitch filter on ps2_clk, frame FSM, prefix folding, FIFO.
// Latency: pin edge to visible entry at most FILTER_LEN+5 cycles; backpressure: none upstream, drops on full.
module ps2_rx_fifo #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] scan_code,
  output logic       scan_break,
  output logic       scan_ext,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } scan_t;

  logic [1:0]    clk_sync, data_sync;
  logic          clk_s, data_s;
  logic          filt_clk, fall;
  logic [FW-1:0] filt_cnt;

  state_t        state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          timeout, shift_en, par_en, stop_chk;
  logic          parity_ok, frame_good, par_bad, stop_bad;

  logic          commit_vld;
  logic [7:0]    commit_code;
  logic          ext_pend, brk_pend;
  logic          push, push_rdy, ovf_evt, head_vld;
  scan_t         push_entry, head;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // Idle PS/2 lines are high, so sync and filter come out of reset at 1 to avoid a false fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt_clk  <= 1'b1;
      filt_cnt  <= '0;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      fall      <= 1'b0;
      if (clk_s != filt_clk) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt_clk <= clk_s;
          filt_cnt <= '0;
          fall     <= !clk_s;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign timeout = (state != S_IDLE) && !fall && (to_cnt >= TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = S_IDLE;
    end else if (fall) begin
      case (state)
        S_IDLE:   if (!data_s) state_nxt = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
        S_PARITY: state_nxt = S_STOP;
        S_STOP:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_chk = 1'b0;
    if (fall) begin
      case (state)
        S_DATA:   shift_en = 1'b1;
        S_PARITY: par_en   = 1'b1;
        S_STOP:   stop_chk = 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (state == S_IDLE) bit_cnt <= '0;
      else if (shift_en)   bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) shift   <= {data_s, shift[7:1]};
      if (par_en)   par_bit <= data_s;
      if (state == S_IDLE || fall) to_cnt <= '0;
      else if (!timeout)           to_cnt <= to_cnt + 1'b1;
    end
  end

  assign parity_ok  = ^{shift, par_bit};
  assign frame_good = stop_chk && data_s && parity_ok;
  assign par_bad    = stop_chk && !parity_ok;
  assign stop_bad   = stop_chk && !data_s;

  // Prefix folding happens one cycle after the stop bit; a discarded frame can never coincide with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_vld  <= 1'b0;
      commit_code <= '0;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
    end else begin
      commit_vld <= frame_good;
      if (frame_good) commit_code <= shift;
      if (par_bad || stop_bad || timeout) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (commit_vld) begin
        if (commit_code == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (commit_code == 8'hF0) begin
          brk_pend <= 1'b1;
        end else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end
    end
  end

  assign push       = commit_vld && (commit_code != 8'hE0) && (commit_code != 8'hF0);
  assign push_entry = '{ext: ext_pend, brk: brk_pend, code: commit_code};
  assign ovf_evt    = push && !push_rdy;

  ps2_rx_fifo_q #(
    .W     ($bits(scan_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (push),
    .wr_dat (push_entry),
    .wr_rdy (push_rdy),
    .rd_rdy (rd_en),
    .rd_vld (head_vld),
    .rd_dat (head),
    .full   (fifo_full)
  );

  // Error events take priority over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (par_bad)              parity_err <= 1'b1;
      else if (clr_err)         parity_err <= 1'b0;
      if (stop_bad || timeout)  frame_err  <= 1'b1;
      else if (clr_err)         frame_err  <= 1'b0;
      if (ovf_evt)              overflow   <= 1'b1;
      else if (clr_err)         overflow   <= 1'b0;
    end
  end

  assign fifo_empty = !head_vld;
  assign scan_code  = head_vld ? head.code : 8'h00;
  assign scan_break = head_vld && head.brk;
  assign scan_ext   = head_vld && head.ext;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: bit-bangs PS/2 frames, checks every settled cycle against a queue model
// plus literal expectations at key points.
module tb_ps2_rx_fifo;
  localparam int FL    = 8;
  localparam int TO    = 500;
  localparam int DEPTH = 4;
  localparam int HALF  = 2000;

  logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] scan_code;
  logic scan_break, scan_ext, fifo_empty, fifo_full, parity_err, frame_err, overflow;
  logic [14:0] dut_vec;

  int tests = 0, fails = 0;
  logic [9:0] mq[$];
  logic m_ext = 1'b0, m_brk = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovf = 1'b0;
  bit chk_en = 1'b0;

  always #20 clk = ~clk;

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT(TO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .clr_err(clr_err), .scan_code(scan_code), .scan_break(scan_break),
    .scan_ext(scan_ext), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );

  assign dut_vec = {scan_code, scan_break, scan_ext, fifo_empty, fifo_full, parity_err, frame_err, overflow};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] model_out();
    logic [9:0] h;
    h = (mq.size() == 0) ? 10'h000 : mq[0];
    return {h[7:0], h[8], h[9], mq.size() == 0, mq.size() == DEPTH, m_perr, m_ferr, m_ovf};
  endfunction

  function automatic void model_frame(input logic [7:0] code, input logic par, input logic stop);
    bit par_ok;
    par_ok = ($countones({code, par}) % 2) == 1;
    if (!par_ok) m_perr = 1'b1;
    if (!stop)   m_ferr = 1'b1;
    if (!par_ok || !stop) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (code == 8'hE0) begin
      m_ext = 1'b1;
    end else if (code == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (mq.size() >= DEPTH) m_ovf = 1'b1;
      else mq.push_back({m_ext, m_brk, code});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ext = 1'b0; m_brk = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
  endfunction

  always @(negedge clk) if (chk_en) chk("cycle", 32'(dut_vec), 32'(model_out()));

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Comparison is suspended across the stop-bit edge while the DUT commits.
  task automatic send_raw(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      #(HALF / 2);
      if (i == 10) chk_en = 1'b0;
      ps2_clk = 1'b0;
      #(HALF);
      ps2_clk = 1'b1;
      #(HALF / 2);
    end
  endtask

  task automatic send_frame(input logic [7:0] code, input logic par, input logic stop);
    send_raw({stop, par, code, 1'b0}, 11);
    model_frame(code, par, stop);
    cycles(1);
    chk_en = 1'b1;
  endtask

  task automatic send_ok(input logic [7:0] code);
    send_frame(code, 1'(($countones(code) % 2) == 0), 1'b1);
  endtask

  task automatic pop(input logic [7:0] exp);
    chk("pop_code", 32'(scan_code), 32'(exp));
    rd_en = 1'b1;
    if (mq.size() > 0) mq.delete(0);
    cycles(1);
    rd_en = 1'b0;
  endtask

  task automatic clear();
    clr_err = 1'b1;
    m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    cycles(1);
    clr_err = 1'b0;
  endtask

  initial begin
    logic [7:0] codes [5];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};

    cycles(1);
    chk("reset_state", 32'(dut_vec), 32'({8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
    reset = 1'b0;
    chk_en = 1'b1;
    cycles(5);

    send_ok(8'h1C);
    chk("first_head", 32'({scan_code, scan_break, scan_ext, fifo_empty}), 32'({8'h1C, 1'b0, 1'b0, 1'b0}));
    pop(8'h1C);
    chk("first_popped", 32'({scan_code, fifo_empty}), 32'({8'h00, 1'b1}));

    send_ok(8'hF0);
    send_ok(8'h1C);
    chk("break_head", 32'({scan_code, scan_break, scan_ext, fifo_empty}), 32'({8'h1C, 1'b1, 1'b0, 1'b0}));
    pop(8'h1C);
    chk("break_single", 32'(fifo_empty), 32'(1));
    send_ok(8'hE0);
    send_ok(8'hF0);
    send_ok(8'h75);
    chk("ext_break_head", 32'({scan_code, scan_break, scan_ext}), 32'({8'h75, 1'b1, 1'b1}));
    pop(8'h75);
    send_ok(8'h1C);
    chk("flags_cleared", 32'({scan_code, scan_break, scan_ext}), 32'({8'h1C, 1'b0, 1'b0}));
    pop(8'h1C);

    send_frame(8'h1C, 1'b1, 1'b1);
    chk("parity_err", 32'({parity_err, frame_err, fifo_empty}), 32'({1'b1, 1'b0, 1'b1}));
    clear();
    chk("parity_cleared", 32'(parity_err), 32'(0));
    send_frame(8'hE0, 1'b0, 1'b0);
    send_ok(8'h74);
    chk("bad_stop_prefix", 32'({frame_err, scan_code, scan_ext}), 32'({1'b1, 8'h74, 1'b0}));
    pop(8'h74);
    clear();

    foreach (codes[i]) send_ok(codes[i]);
    chk("overflow", 32'({fifo_full, overflow, scan_code}), 32'({1'b1, 1'b1, 8'h15}));
    pop(8'h15);
    pop(8'h1D);
    pop(8'h24);
    pop(8'h2D);
    chk("drained", 32'({fifo_empty, scan_code}), 32'({1'b1, 8'h00}));
    clear();

    send_raw({1'b1, 1'b1, 8'h55, 1'b0}, 6);
    chk_en = 1'b0;
    cycles(TO + 10);
    m_ferr = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
    chk_en = 1'b1;
    chk("timeout", 32'({frame_err, fifo_empty}), 32'({1'b1, 1'b1}));
    send_ok(8'h1C);
    chk("after_timeout", 32'({scan_code, scan_break, scan_ext, fifo_empty}), 32'({8'h1C, 1'b0, 1'b0, 1'b0}));

    send_raw({1'b1, 1'b0, 8'h2A, 1'b0}, 4);
    reset = 1'b1;
    model_reset();
    #1;
    chk("reset_mid_frame", 32'(dut_vec), 32'({8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
    cycles(3);
    reset = 1'b0;
    cycles(5);
    send_ok(8'h1C);
    chk("after_reset", 32'({scan_code, scan_break, scan_ext, fifo_empty}), 32'({8'h1C, 1'b0, 1'b0, 1'b0}));
    pop(8'h1C);

    ps2_data = 1'b0;
    for (int g = 0; g < 5; g++) begin
      ps2_clk = 1'b0;
      #120;
      ps2_clk = 1'b1;
      cycles(10);
    end
    cycles(50);
    ps2_data = 1'b1;
    send_ok(8'h1C);
    chk("after_glitch", 32'({scan_code, scan_break, scan_ext, fifo_empty, frame_err}), 32'({8'h1C, 1'b0, 1'b0, 1'b0, 1'b0}));
    pop(8'h1C);
    chk("glitch_single", 32'(fifo_empty), 32'(1));

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
